// File: rtl/p4_adder_arbiter.sv
// p4_adder_arbiter: time-shares one combinational P4 adder among NREQ requesters.
// Requests are granted round-robin, operands are registered onto the adder, the
// adder is allowed ADD_LAT cycles to settle, and the captured sum/carry is
// returned with the owner's index over a valid/ready response channel.
module p4_adder_arbiter #(
   parameter int NREQ    = 4,
   parameter int NBIT    = 32,
   parameter int ADD_LAT = 2,
   localparam int IDW    = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*NBIT-1:0] req_a,
   input  logic [NREQ*NBIT-1:0] req_b,
   input  logic [NREQ-1:0]      req_cin,
   output logic [NBIT-1:0]      add_a,
   output logic [NBIT-1:0]      add_b,
   output logic                 add_cin,
   input  logic [NBIT-1:0]      add_s,
   input  logic                 add_cout,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [NBIT-1:0]      rsp_s,
   output logic                 rsp_cout
);

   // settle counter only needs to hold ADD_LAT-1
   localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_reg;
   logic [IDW-1:0]  rr_ptr_reg;
   logic [CW-1:0]   cnt_reg;
   logic [IDW-1:0]  owner_reg;

   logic [NBIT-1:0] a_arr [NREQ];
   logic [NBIT-1:0] b_arr [NREQ];
   logic [IDW-1:0]  cand_idx [NREQ];
   logic [IDW-1:0]  gnt_idx;
   logic            gnt_any;
   logic [IDW-1:0]  ptr_after;
   logic            accept;

   // unpack the flat operand buses and build the search order starting at rr_ptr
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      logic [IDW:0] wide_idx;

      assign a_arr[gi]    = req_a[gi*NBIT +: NBIT];
      assign b_arr[gi]    = req_b[gi*NBIT +: NBIT];
      assign wide_idx     = {1'b0, rr_ptr_reg} + (IDW+1)'(gi);
      assign cand_idx[gi] = (wide_idx >= (IDW+1)'(NREQ))
                            ? IDW'(wide_idx - (IDW+1)'(NREQ))
                            : wide_idx[IDW-1:0];
   end

   // round-robin pick: the earliest valid requester in rotated order wins
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid[cand_idx[k]]) begin
            gnt_any = 1'b1;
            gnt_idx = cand_idx[k];
         end
      end
   end

   // pointer moves one past the winner so it becomes lowest priority next time
   always_comb begin
      if (gnt_idx == IDW'(NREQ - 1))
         ptr_after = '0;
      else
         ptr_after = gnt_idx + 1'b1;
   end

   // ready is only offered while idle; reset masks it immediately
   always_comb begin
      req_ready = '0;
      if ((state_reg == IDLE) && gnt_any && !rst)
         req_ready[gnt_idx] = 1'b1;
   end

   assign accept = (state_reg == IDLE) && gnt_any;

   // control FSM: accept operands, wait for the adder to settle, hold the result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         rr_ptr_reg <= '0;
         cnt_reg    <= '0;
         owner_reg  <= '0;
         add_a      <= '0;
         add_b      <= '0;
         add_cin    <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_s      <= '0;
         rsp_cout   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  add_a      <= a_arr[gnt_idx];
                  add_b      <= b_arr[gnt_idx];
                  add_cin    <= req_cin[gnt_idx];
                  owner_reg  <= gnt_idx;
                  rr_ptr_reg <= ptr_after;
                  cnt_reg    <= CW'(ADD_LAT - 1);
                  state_reg  <= BUSY;
               end
            end
            BUSY: begin
               // adder inputs stay frozen; capture once the multicycle window closes
               if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - 1'b1;
               end else begin
                  rsp_s     <= add_s;
                  rsp_cout  <= add_cout;
                  rsp_id    <= owner_reg;
                  rsp_valid <= 1'b1;
                  state_reg <= RESP;
               end
            end
            RESP: begin
               // result is held until the consumer takes it
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
